// File: rtl/booth_pkg.sv
// Shared state encoding, default parameters and width helper for the
// Booth multiplier operand sequencer.
package booth_pkg;

   localparam int W_DEF       = 3;
   localparam int DEPTH_DEF   = 4;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   function automatic int resWidth(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO with full/empty flags; head entry is visible
// combinationally on popData_o whenever the FIFO is not empty.
module booth_op_fifo
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] popData_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q;
   logic [AW:0]      rdPtr_q;
   logic             doPush;
   logic             doPop;

   // The extra pointer bit separates a full FIFO from an empty one.
   assign empty_o   = (wrPtr_q == rdPtr_q);
   assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPush    = push_i && !full_o;
   assign doPop     = pop_i && !empty_o;
   assign popData_o = mem_q[rdPtr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/booth_op_sequencer.sv
// Feeds buffered operand pairs to the Booth multiplier one at a time and
// captures each product into a valid/ready slot. BOOTH_SEQ_TIMEOUT_EN adds a WAIT watchdog.
module booth_op_sequencer
   import booth_pkg::*;
#(
   parameter int W              = W_DEF,
   parameter int DEPTH          = DEPTH_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_multiplicador,
   input  logic [W-1:0]     in_multiplicando,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_resultado,
   output logic [W-1:0]     mul_multiplicador,
   output logic [W-1:0]     mul_multiplicando,
   output logic             mul_start,
   input  logic [2*W-1:0]   mul_resultado,
   input  logic             mul_fin,
   output logic             busy,
   output logic             err
);

   localparam int RW = resWidth(W);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : gBadConfig
      $error("booth_op_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
   end

   logic          fifoFull;
   logic          fifoEmpty;
   logic          fifoPop;
   logic [RW-1:0] fifoHead;

   state_t        state_q;
   logic [W-1:0]  mulMultiplicador_q;
   logic [W-1:0]  mulMultiplicando_q;
   logic          mulStart_q;
   logic          firstWait_q;
   logic          outValid_q;
   logic [RW-1:0] outResultado_q;

   logic          finHonoured;
   logic          capture;

   booth_op_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) uFifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (in_valid),
      .pushData_i ({in_multiplicador, in_multiplicando}),
      .full_o     (fifoFull),
      .pop_i      (fifoPop),
      .popData_o  (fifoHead),
      .empty_o    (fifoEmpty)
   );

   // A fin seen in the first WAIT cycle may be left over from the previous operation.
   assign fifoPop     = (state_q == IDLE) && !fifoEmpty;
   assign finHonoured = (state_q == WAIT) && mul_fin && !firstWait_q;
   assign capture     = finHonoured && (!outValid_q || out_ready);

   assign in_ready          = !fifoFull;
   assign out_valid         = outValid_q;
   assign out_resultado     = outResultado_q;
   assign mul_multiplicador = mulMultiplicador_q;
   assign mul_multiplicando = mulMultiplicando_q;
   assign mul_start         = mulStart_q;
   assign busy              = (state_q != IDLE);

`ifdef BOOTH_SEQ_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] waitCnt_q;
   logic            finSeen_q;
   logic            err_q;

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= IDLE;
         mulMultiplicador_q <= '0;
         mulMultiplicando_q <= '0;
         mulStart_q         <= 1'b0;
         firstWait_q        <= 1'b0;
         outValid_q         <= 1'b0;
         outResultado_q     <= '0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
         waitCnt_q          <= '0;
         finSeen_q          <= 1'b0;
         err_q              <= 1'b0;
`endif
      end else begin
         if (capture) begin
            outValid_q     <= 1'b1;
            outResultado_q <= mul_resultado;
         end else if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!fifoEmpty) begin
                  mulMultiplicador_q <= fifoHead[RW-1:W];
                  mulMultiplicando_q <= fifoHead[W-1:0];
                  mulStart_q         <= 1'b1;
                  state_q            <= ISSUE;
               end
            end
            ISSUE: begin
               mulStart_q  <= 1'b0;
               firstWait_q <= 1'b1;
               state_q     <= WAIT;
`ifdef BOOTH_SEQ_TIMEOUT_EN
               waitCnt_q   <= '0;
               finSeen_q   <= 1'b0;
`endif
            end
            WAIT: begin
               firstWait_q <= 1'b0;
               if (capture) begin
                  state_q <= IDLE;
               end
`ifdef BOOTH_SEQ_TIMEOUT_EN
               // Once fin is honoured a stall is only backpressure, not a fault.
               if (finHonoured) begin
                  finSeen_q <= 1'b1;
               end else if (!finSeen_q) begin
                  if (waitCnt_q == CntLast) begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     waitCnt_q <= waitCnt_q + 1'b1;
                  end
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
